// File: rtl/md_unit_if.sv
// Issue/result bundle between the ID/EX stage and the multiply/divide unit.
`timescale 1ns/1ps
interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, op, A, B, input busy, HI, LO);
    modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit owning the architectural HI/LO registers.
`timescale 1ns/1ps
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_busy;

    logic            w_issue_mul;
    logic            w_issue_div;
    logic            w_res_mul;
    logic [2*W-1:0]  w_prod_s;
    logic [2*W-1:0]  w_prod_u;
    logic [2*W-1:0]  w_prod;
    logic            w_div_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_dvd;
    logic [W-1:0]    w_dvs;
    logic            w_dvs_zero;
    logic [W-1:0]    w_uq;
    logic [W-1:0]    w_ur;
    logic [W-1:0]    w_q;
    logic [W-1:0]    w_r;

    assign w_issue_mul = bus.start && ((bus.op == OP_MULT) || (bus.op == OP_MULTU));
    assign w_issue_div = bus.start && ((bus.op == OP_DIV)  || (bus.op == OP_DIVU));

    // Results are formed from the latched operands and committed on the last RUN edge
    assign w_res_mul = (r_op == OP_MULT) || (r_op == OP_MULTU);
    assign w_prod_s  = $signed({{W{r_a[W-1]}}, r_a}) * $signed({{W{r_b[W-1]}}, r_b});
    assign w_prod_u  = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
    assign w_prod    = (r_op == OP_MULT) ? w_prod_s : w_prod_u;

    // Signed divide via magnitudes; -2^31 / -1 naturally yields 0x80000000 rem 0
    assign w_div_signed = (r_op == OP_DIV);
    assign w_a_neg      = w_div_signed && r_a[W-1];
    assign w_b_neg      = w_div_signed && r_b[W-1];
    assign w_dvd        = w_a_neg ? (~r_a + W'(1)) : r_a;
    assign w_dvs        = w_b_neg ? (~r_b + W'(1)) : r_b;
    assign w_dvs_zero   = (r_b == '0);
    assign w_uq         = w_dvs_zero ? '0 : (w_dvd / w_dvs);
    assign w_ur         = w_dvs_zero ? '0 : (w_dvd % w_dvs);
    assign w_q          = (w_a_neg ^ w_b_neg) ? (~w_uq + W'(1)) : w_uq;
    assign w_r          = w_a_neg ? (~w_ur + W'(1)) : w_ur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue_mul || w_issue_div) begin
                        r_op    <= bus.op;
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_cnt   <= w_issue_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else if (bus.start && (bus.op == OP_MTHI)) begin
                        r_hi <= bus.A;
                    end else if (bus.start && (bus.op == OP_MTLO)) begin
                        r_lo <= bus.A;
                    end
                end
                S_RUN: begin
                    if (r_cnt <= CW'(1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_res_mul) begin
                            r_hi <= w_prod[2*W-1:W];
                            r_lo <= w_prod[W-1:0];
                        end else if (!w_dvs_zero) begin
                            r_hi <= w_r;
                            r_lo <= w_q;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule
